ofdm_sym_sched: RTL and testbench

Frame/symbol scheduler in front of the pilot-insertion → IFFT chain. It accepts a Wishbone-style write stream of data-subcarrier samples. It forwards them downstream in whole OFDM symbols of `NDATA` samples, enforces a configured symbols-per-frame count, and zero-pads a symbol truncated by the source. It also inserts an idle gap between frames so the downstream IFFT always sees complete, well-delimited symbols.

---
 rtl/ofdm_pkg.sv | 17 +
 rtl/ofdm_sym_sched_if.sv | 13 +
 rtl/wb_out_reg.sv | 30 +++
 rtl/ofdm_sym_sched.sv | 158 +++++++++++++++
 tb/tb_ofdm_sym_sched.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ofdm_pkg.sv
// Shared types and defaults for the OFDM symbol scheduler.
package ofdm_pkg;

  localparam int NDATA_DEF = 48;
  localparam int SAMP_W    = 32;

  typedef logic [SAMP_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_PAD,
    ST_DRAIN,
    ST_GAP
  } state_t;

endpackage

// File: rtl/ofdm_sym_sched_if.sv
// Wishbone-style write-only stream link: one sample moves per STB/ACK transfer.
interface ofdm_sym_sched_if;

  ofdm_pkg::sample_t dat;
  logic              we;
  logic              stb;
  logic              cyc;
  logic              ack;

  modport master (output dat, we, stb, cyc, input ack);
  modport slave  (input dat, we, stb, cyc, output ack);

endinterface

// File: rtl/wb_out_reg.sv
// Single-entry downstream output register: loads when empty or being drained,
// with a zero-load option used while padding a truncated symbol.
module wb_out_reg
  import ofdm_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    ack,
  input  logic    load,
  input  logic    zero,
  input  sample_t din,
  output sample_t dat,
  output logic    stb,
  output logic    free
);

  assign free = ~stb | ack;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dat <= '0;
      stb <= 1'b0;
    end else if (free) begin
      stb <= load;
      if (load) dat <= zero ? '0 : din;
    end
  end

endmodule

// File: rtl/ofdm_sym_sched.sv
// Frame/symbol scheduler: forwards whole OFDM symbols, pads truncated ones,
// enforces the per-frame symbol count and inserts an idle gap between frames.
module ofdm_sym_sched
  import ofdm_pkg::*;
#(
  parameter int NDATA  = NDATA_DEF,
  parameter int NSYM_W = 8,
  parameter int GAP    = 4
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [NSYM_W-1:0] NSYM_I,
  ofdm_sym_sched_if.slave   up,
  ofdm_sym_sched_if.master  dn,
  output logic              FRM_DONE_O,
  output logic              TRUNC_O,
  output logic [NSYM_W-1:0] SYM_CNT_O
);

  localparam int          SW        = $clog2(NDATA);
  localparam int          GW        = $clog2(GAP + 1);
  localparam logic [SW-1:0] LAST_SAMP = SW'(NDATA - 1);

  state_t            state, state_nxt;
  sample_t           dat_q;
  logic              stb_q, cyc_q, free, load, zero;
  logic              up_xfer, dn_xfer, in_last;
  logic              frame_start, trunc_set, drain_done, trunc_q;
  logic [NSYM_W-1:0] nsym, in_sym, sym_cnt;
  logic [SW-1:0]     in_samp, samp_cnt;
  logic [GW-1:0]     gap_cnt;

  wb_out_reg u_out (
    .clk   (CLK_I),
    .rst_n (RST_I),
    .ack   (dn.ack),
    .load  (load),
    .zero  (zero),
    .din   (up.dat),
    .dat   (dat_q),
    .stb   (stb_q),
    .free  (free)
  );

  assign dn.dat    = dat_q;
  assign dn.stb    = stb_q;
  assign dn.we     = stb_q;
  assign dn.cyc    = cyc_q;
  assign up.ack    = (state == ST_STREAM) & free;
  assign up_xfer   = up.cyc & up.stb & up.we & up.ack;
  assign dn_xfer   = stb_q & dn.ack;
  assign SYM_CNT_O = sym_cnt;

  // in_samp/in_sym track accepted (or padded) samples, so they already include the in-flight one.
  assign in_last = (in_samp == LAST_SAMP) && (in_sym == nsym - NSYM_W'(1));

  always_ff @(posedge CLK_I) begin
    if (!RST_I) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    zero        = 1'b0;
    frame_start = 1'b0;
    trunc_set   = 1'b0;
    drain_done  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (up.cyc && up.stb && up.we && (NSYM_I != '0)) begin
          state_nxt   = ST_STREAM;
          frame_start = 1'b1;
        end
      end
      ST_STREAM: begin
        load = up_xfer;
        if (up_xfer && in_last) begin
          state_nxt = ST_DRAIN;
        end else if (!up.cyc) begin
          if (in_samp != '0) begin
            state_nxt = ST_PAD;
          end else begin
            state_nxt = ST_DRAIN;
            trunc_set = 1'b1;
          end
        end
      end
      ST_PAD: begin
        load = free;
        zero = 1'b1;
        if (free && (in_samp == LAST_SAMP)) begin
          state_nxt = ST_DRAIN;
          trunc_set = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (free) begin
          state_nxt  = ST_GAP;
          drain_done = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      nsym       <= '0;
      in_samp    <= '0;
      in_sym     <= '0;
      samp_cnt   <= '0;
      sym_cnt    <= '0;
      gap_cnt    <= '0;
      trunc_q    <= 1'b0;
      cyc_q      <= 1'b0;
      FRM_DONE_O <= 1'b0;
      TRUNC_O    <= 1'b0;
    end else begin
      FRM_DONE_O <= drain_done;
      TRUNC_O    <= drain_done & trunc_q;
      gap_cnt    <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
      if (frame_start) begin
        nsym     <= NSYM_I;
        in_samp  <= '0;
        in_sym   <= '0;
        samp_cnt <= '0;
        sym_cnt  <= '0;
        trunc_q  <= 1'b0;
      end else begin
        if (load) begin
          if (in_samp == LAST_SAMP) begin
            in_samp <= '0;
            in_sym  <= in_sym + NSYM_W'(1);
          end else begin
            in_samp <= in_samp + SW'(1);
          end
        end
        if (dn_xfer) begin
          if (samp_cnt == LAST_SAMP) begin
            samp_cnt <= '0;
            sym_cnt  <= sym_cnt + NSYM_W'(1);
          end else begin
            samp_cnt <= samp_cnt + SW'(1);
          end
        end
        if (trunc_set) trunc_q <= 1'b1;
      end
      if (load)            cyc_q <= 1'b1;
      else if (drain_done) cyc_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofdm_sym_sched.sv
// Directed bench for ofdm_sym_sched: full, back-pressured, padded, short,
// disabled and reset-aborted frames against hand-computed sample sequences.
module tb_ofdm_sym_sched;
  import ofdm_pkg::*;

  localparam int NDATA  = 48;
  localparam int NSYM_W = 8;
  localparam int GAP    = 4;
  localparam int LIMIT  = 2000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSYM_W-1:0] nsym;
  logic              frm_done, trunc;
  logic [NSYM_W-1:0] sym_cnt;

  ofdm_sym_sched_if up_if ();
  ofdm_sym_sched_if dn_if ();

  int      n_checks = 0;
  int      n_errors = 0;
  bit      ack_toggle = 1'b0;
  int      ack_phase = 0;
  sample_t got_q[$];
  sample_t exp_q[$];
  bit      hold_pend = 1'b0;
  sample_t hold_dat = '0;
  int      hold_err = 0;

  always #5 clk = ~clk;

  ofdm_sym_sched #(.NDATA(NDATA), .NSYM_W(NSYM_W), .GAP(GAP)) dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .NSYM_I     (nsym),
    .up         (up_if),
    .dn         (dn_if),
    .FRM_DONE_O (frm_done),
    .TRUNC_O    (trunc),
    .SYM_CNT_O  (sym_cnt)
  );

  // Downstream acknowledge: always 1, or a repeating 3-low / 5-high pattern.
  always @(posedge clk) begin
    #1;
    if (ack_toggle) begin
      dn_if.ack = (ack_phase >= 3);
      ack_phase = (ack_phase + 1) % 8;
    end else begin
      dn_if.ack = 1'b1;
      ack_phase = 0;
    end
  end

  // Capture every downstream transfer and flag any change of a stalled sample.
  always @(negedge clk) begin
    if (hold_pend && (dn_if.stb !== 1'b1 || dn_if.dat !== hold_dat)) hold_err++;
    hold_pend = (dn_if.stb === 1'b1) && (dn_if.ack === 1'b0);
    hold_dat  = dn_if.dat;
    if (dn_if.stb === 1'b1 && dn_if.ack === 1'b1) got_q.push_back(dn_if.dat);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int n, input int start, input bit keep);
    for (int i = 0; i < n; i++) begin
      int t;
      bit got;
      t   = 0;
      got = 1'b0;
      up_if.dat = 32'(start + i);
      up_if.cyc = 1'b1;
      up_if.stb = 1'b1;
      up_if.we  = 1'b1;
      while (!got && t < LIMIT) begin
        @(negedge clk);
        got = (up_if.ack === 1'b1);
        @(posedge clk);
        #1;
        t++;
      end
      if (!got) begin
        check("send_timeout", 32'(got), 32'(1));
        break;
      end
    end
    if (!keep) begin
      up_if.cyc = 1'b0;
      up_if.stb = 1'b0;
      up_if.we  = 1'b0;
    end
  endtask

  task automatic wait_done(output logic t, output logic [NSYM_W-1:0] s);
    int n;
    n = 0;
    while (frm_done !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("frm_done_seen", 32'(frm_done), 32'(1));
    t = trunc;
    s = sym_cnt;
  endtask

  task automatic expect_frame(input int n_data, input int start, input int n_pad,
                              input logic t_exp, input int s_exp);
    logic              t;
    logic [NSYM_W-1:0] s;
    wait_done(t, s);
    check("trunc", 32'(t), 32'(t_exp));
    check("sym_cnt", 32'(s), 32'(s_exp));
    exp_q.delete();
    for (int i = 0; i < n_data; i++) exp_q.push_back(32'(start + i));
    for (int i = 0; i < n_pad; i++)  exp_q.push_back('0);
    check("data_len", 32'(got_q.size()), 32'(exp_q.size()));
    if (got_q.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        check("data", got_q[i], exp_q[i]);
        if (got_q[i] !== exp_q[i]) break;
      end
    end
    got_q.delete();
  endtask

  initial begin
    int k, low, extra, a, b;
    rst       = 1'b0;
    nsym      = '0;
    up_if.dat = '0;
    up_if.cyc = 1'b0;
    up_if.stb = 1'b0;
    up_if.we  = 1'b0;

    @(posedge clk);
    @(negedge clk);
    check("rst_stb",   32'(dn_if.stb), 32'(0));
    check("rst_we",    32'(dn_if.we),  32'(0));
    check("rst_cyc",   32'(dn_if.cyc), 32'(0));
    check("rst_ack",   32'(up_if.ack), 32'(0));
    check("rst_dat",   dn_if.dat,      32'(0));
    check("rst_done",  32'(frm_done),  32'(0));
    check("rst_trunc", 32'(trunc),     32'(0));
    check("rst_sym",   32'(sym_cnt),   32'(0));
    @(posedge clk);
    #1 rst = 1'b1;

    // Two full symbols, samples 1..96, ACK_I held high.
    nsym = NSYM_W'(2);
    send(96, 1, 1'b0);
    expect_frame(96, 1, 0, 1'b0, 2);

    // Same frame again under back-pressure, launched straight from the done pulse.
    ack_toggle = 1'b1;
    hold_err   = 0;
    k     = 0;
    low   = 0;
    extra = 0;
    fork
      send(96, 1, 1'b0);
      begin
        while (up_if.ack !== 1'b1 && k < 50) begin
          if (k < GAP && dn_if.cyc === 1'b0) low++;
          if (k > 0 && frm_done === 1'b1) extra++;
          @(negedge clk);
          k++;
        end
      end
    join
    check("gap_cyc_low",    32'(low),             32'(GAP));
    check("gap_ack_min",    32'(k >= GAP + 1),    32'(1));
    check("done_pulse_len", 32'(extra),           32'(0));
    expect_frame(96, 1, 0, 1'b0, 2);
    check("hold_stable", 32'(hold_err), 32'(0));
    ack_toggle = 1'b0;

    // Source drops CYC_I after 60 samples: remaining 36 go out as zeros.
    nsym = NSYM_W'(2);
    send(60, 1, 1'b0);
    expect_frame(60, 1, 36, 1'b1, 2);

    // Source stops on a symbol boundary before the configured count.
    nsym = NSYM_W'(3);
    send(48, 101, 1'b0);
    expect_frame(48, 101, 0, 1'b1, 1);

    // NSYM_I of zero never starts a frame.
    nsym      = '0;
    up_if.dat = 32'(7);
    up_if.cyc = 1'b1;
    up_if.stb = 1'b1;
    up_if.we  = 1'b1;
    a = 0;
    b = 0;
    repeat (200) begin
      @(negedge clk);
      if (up_if.ack !== 1'b0) a++;
      if (dn_if.stb !== 1'b0) b++;
    end
    check("nsym0_ack", 32'(a), 32'(0));
    check("nsym0_stb", 32'(b), 32'(0));
    up_if.cyc = 1'b0;
    up_if.stb = 1'b0;
    up_if.we  = 1'b0;

    // Reset pulse after sample 30 aborts the frame without a done pulse.
    nsym = NSYM_W'(2);
    send(30, 1, 1'b1);
    rst       = 1'b0;
    up_if.cyc = 1'b0;
    up_if.stb = 1'b0;
    up_if.we  = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("arst_stb",   32'(dn_if.stb), 32'(0));
    check("arst_we",    32'(dn_if.we),  32'(0));
    check("arst_cyc",   32'(dn_if.cyc), 32'(0));
    check("arst_ack",   32'(up_if.ack), 32'(0));
    check("arst_dat",   dn_if.dat,      32'(0));
    check("arst_done",  32'(frm_done),  32'(0));
    check("arst_trunc", 32'(trunc),     32'(0));
    check("arst_sym",   32'(sym_cnt),   32'(0));
    a = 0;
    repeat (20) begin
      @(negedge clk);
      if (frm_done !== 1'b0) a++;
    end
    check("arst_no_done", 32'(a), 32'(0));
    got_q.delete();

    // Clean single-symbol frame after the abort.
    nsym = NSYM_W'(1);
    send(48, 1, 1'b0);
    expect_frame(48, 1, 0, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
